// File: rtl/screen_pkg.sv
// screen_pkg: shared state encoding, default geometry and word-index helper
// for the frame buffer and its raster scan-out engine.
// Ports: none (package).
package screen_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // Default geometry: 512x256 pixels, 16-bit words, 8K words.
  localparam int DEF_DATA_W        = 16;
  localparam int DEF_WORDS_PER_ROW = 32;
  localparam int DEF_ROWS          = 256;
  localparam int DEF_ADDR_W        = 13;
  localparam int DEF_X_W           = 9;
  localparam int DEF_Y_W           = 8;

  // Linear word index of (row, col) in row-major order.
  function automatic int lin_index(input int row, input int col, input int words_per_row);
    return row * words_per_row + col;
  endfunction

endpackage

// File: rtl/screen_scan.sv
// screen_scan: raster scan-out engine; shifts 1-bit pixels out of a word register.
// Ports: start/keep control from the parent FSM, rd_addr/rd_data scan read port,
// pixel stream (valid/ready, data, x, y, frame_start) and a frame_done pulse.
module screen_scan
  import screen_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int ROWS          = DEF_ROWS,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int X_W           = DEF_X_W,
  parameter int Y_W           = DEF_Y_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              keep,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              frame_start
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_q;
  logic [COL_W-1:0]  col_q;
  logic [Y_W-1:0]    row_q;
  logic [ADDR_W-1:0] cur_word;
  logic              xfer;
  logic              last_bit;
  logic              last_col;
  logic              last_row;

  assign xfer     = pix_valid & pix_ready;
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));
  assign last_col = (col_q == COL_W'(WORDS_PER_ROW - 1));
  assign last_row = (row_q == Y_W'(ROWS - 1));

  assign frame_done = xfer & last_bit & last_col & last_row;

  // Counters sit at zero whenever the stream is idle, so the idle read
  // address is word 0 (the start fetch). While streaming, always look one
  // word ahead; the buffer size is a power of two, so +1 wraps to word 0.
  assign cur_word = ADDR_W'(lin_index(int'(row_q), int'(col_q), WORDS_PER_ROW));
  assign rd_addr  = pix_valid ? cur_word + ADDR_W'(1) : '0;

  assign pix_data    = shreg[0];
  assign pix_x       = X_W'(int'(col_q) * DATA_W + int'(bit_q));
  assign pix_y       = row_q;
  assign frame_start = pix_valid & (col_q == '0) & (bit_q == '0) & (row_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      shreg     <= '0;
      bit_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else if (start) begin
      pix_valid <= 1'b1;
      shreg     <= rd_data;
      bit_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else if (xfer) begin
      if (last_bit) begin
        // Refill on the same edge the last bit leaves: no bubble.
        shreg <= rd_data;
        bit_q <= '0;
        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q     <= '0;
            pix_valid <= keep;
          end else begin
            row_q <= row_q + Y_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end else begin
        shreg <= shreg >> 1;
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/screen_buffer.sv
// screen_buffer: word-addressed frame buffer with CPU port, clear sequencer and
// raster scan-out. Ports: clk/reset, CPU in/load/address/out, clear_req, scan_en,
// busy, and the pixel stream pix_valid/pix_ready/pix_data/pix_x/pix_y/frame_start.
module screen_buffer
  import screen_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int ROWS          = DEF_ROWS,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int X_W           = DEF_X_W,
  parameter int Y_W           = DEF_Y_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  input  logic              clear_req,
  input  logic              scan_en,
  output logic              busy,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              frame_start
);

  localparam int NWORDS = 1 << ADDR_W;

  if (NWORDS != WORDS_PER_ROW * ROWS) begin : g_geom_check
    $error("screen_buffer: 2**ADDR_W must equal WORDS_PER_ROW*ROWS");
  end

  logic [DATA_W-1:0] mem [NWORDS];

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              pending;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_start;
  logic              frame_done;
  logic              clear_now;
  logic              keep;

  assign out        = mem[address];
  assign scan_rdata = mem[scan_addr];

  assign scan_start = (state == IDLE) & ~clear_req & scan_en;
  // A clear_req arriving on the frame's final edge counts as pending too.
  assign clear_now  = pending | clear_req;
  assign keep       = scan_en & ~clear_now;

  // Scan fetches read the pre-edge word, so a CPU write on the fetch edge
  // is not seen by that fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (load) begin
        mem[address] <= in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
      pending <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end else if (scan_en) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (clear_req) begin
            pending <= 1'b1;
          end
          if (frame_done && !keep) begin
            if (clear_now) begin
              state   <= CLEAR;
              clr_ptr <= '0;
              busy    <= 1'b1;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
          pending <= 1'b0;
        end
      endcase
    end
  end

  screen_scan #(
    .DATA_W        (DATA_W),
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .ROWS          (ROWS),
    .ADDR_W        (ADDR_W),
    .X_W           (X_W),
    .Y_W           (Y_W)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .start       (scan_start),
    .keep        (keep),
    .rd_data     (scan_rdata),
    .rd_addr     (scan_addr),
    .frame_done  (frame_done),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_screen_buffer.sv
// tb_screen_buffer: directed scenarios plus randomized traffic on a reduced
// 64x4 geometry, checked every cycle against a pixel-index based model.
// Ports: none (testbench top).
module tb_screen_buffer;

  localparam int DW     = 16;
  localparam int WPR    = 4;
  localparam int RW     = 4;
  localparam int AW     = 4;
  localparam int XW     = 6;
  localparam int YW     = 2;
  localparam int NW     = WPR * RW;
  localparam int ROWPIX = WPR * DW;
  localparam int NPIX   = ROWPIX * RW;

  localparam int M_CLR  = 0;
  localparam int M_IDLE = 1;
  localparam int M_SCAN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din = '0;
  logic          load = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] dout;
  logic          clear_req = 1'b0;
  logic          scan_en = 1'b0;
  logic          busy;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;

  screen_buffer #(
    .DATA_W(DW), .WORDS_PER_ROW(WPR), .ROWS(RW), .ADDR_W(AW), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .address(address), .out(dout),
    .clear_req(clear_req), .scan_en(scan_en), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Behavioural model: a linear pixel index plus the word captured at fetch.
  int            m_state;
  int            m_ptr;
  bit            m_pend;
  bit            m_valid;
  int            m_p;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_mem [NW];
  bit            m_known [NW];

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  int tx_cnt = 0, fs_cnt = 0, inval_cnt = 0;
  int last_x = 0, last_y = 0;
  bit pixmap [NPIX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int prev;
    if (reset) begin
      m_state = M_CLR; m_ptr = 0; m_pend = 0; m_valid = 0; m_p = 0; m_word = '0;
      return;
    end
    prev = m_state;
    case (m_state)
      M_CLR: begin
        m_mem[m_ptr] = '0;
        m_known[m_ptr] = 1;
        m_ptr++;
        if (m_ptr == NW) m_state = M_IDLE;
      end
      M_IDLE: begin
        if (clear_req) begin
          m_state = M_CLR; m_ptr = 0;
        end else if (scan_en) begin
          m_state = M_SCAN; m_valid = 1; m_p = 0; m_word = m_mem[0];
        end
      end
      default: begin
        if (clear_req) m_pend = 1;
        if (m_valid && pix_ready) begin
          if (m_p % DW == DW - 1) m_word = m_mem[(m_p / DW + 1) % NW];
          if (m_p == NPIX - 1 && !(scan_en && !m_pend)) begin
            m_valid = 0;
            if (m_pend) begin
              m_state = M_CLR; m_ptr = 0; m_pend = 0;
            end else begin
              m_state = M_IDLE;
            end
          end
          m_p = (m_p + 1) % NPIX;
        end
      end
    endcase
    if (prev != M_CLR && load) begin
      m_mem[address] = din;
      m_known[address] = 1;
    end
  endtask

  task automatic compare();
    chk("busy", busy, 32'(m_state == M_CLR));
    chk("pix_valid", pix_valid, 32'(m_valid));
    chk("pix_data", pix_data, 32'(m_word[m_p % DW]));
    chk("pix_x", pix_x, 32'(m_p % ROWPIX));
    chk("pix_y", pix_y, 32'(m_p / ROWPIX));
    chk("frame_start", frame_start, 32'(m_valid && m_p == 0));
    if (m_known[address]) chk("out", dout, 32'(m_mem[address]));
  endtask

  task automatic record();
    if (pix_valid && pix_ready) begin
      tx_cnt++;
      if (frame_start) fs_cnt++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      pixmap[int'(pix_y) * ROWPIX + int'(pix_x)] = pix_data;
    end
    if (!pix_valid) inval_cnt++;
  endtask

  // Entered just after a negedge with inputs already driven.
  task automatic cycle();
    #1;
    if (chk_en) compare();
    record();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic timeout(input string nm);
    nerr++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  int busy_cnt, g, ones;
  logic [DW-1:0] w2, w3;

  initial begin
    for (int i = 0; i < NW; i++) m_known[i] = 0;
    @(negedge clk);

    // 1: reset, clear length, dropped write during clear, cleared contents
    reset = 1;
    cycle();
    chk_en = 1;
    cycle();
    reset = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      busy_cnt++;
      load    = (i == 10);
      address = 4'd5;
      din     = 16'hFFFF;
      cycle();
    end
    load = 0;
    chk("busy_cycles", busy_cnt, NW);
    address = 4'd0;  cycle(); chk("out_a0", dout, 0);
    address = 4'd7;  cycle(); chk("out_a7", dout, 0);
    address = 4'd15; cycle(); chk("out_a15", dout, 0);
    address = 4'd5;  cycle(); chk("out_a5_dropped", dout, 0);

    // 2: pixel order and word boundaries
    load = 1; address = 4'd0; din = 16'h8001; cycle();
    address = 4'(WPR); din = 16'h0003; cycle();
    load = 0; scan_en = 1; pix_ready = 1;
    for (g = 0; g < 10 && !pix_valid; g++) cycle();
    if (!pix_valid) timeout("first_valid");
    chk("first_fs", frame_start, 1);
    chk("first_x", pix_x, 0);
    chk("first_y", pix_y, 0);
    chk("first_data", pix_data, 1);
    tx_cnt = 0; inval_cnt = 0;
    for (g = 0; g < 2000 && tx_cnt < NPIX; g++) cycle();
    if (tx_cnt < NPIX) timeout("frame2");
    ones = 0;
    for (int i = 1; i <= 14; i++) ones += pixmap[i];
    chk("x15_data", pixmap[15], 1);
    chk("x1_14_zero", ones, 0);
    chk("row1_x0", pixmap[ROWPIX], 1);
    chk("row1_x1", pixmap[ROWPIX + 1], 1);
    chk("no_bubble", inval_cnt, 0);
    chk("wrap_fs", frame_start, 1);

    // 3: backpressure 1010...
    tx_cnt = 0; fs_cnt = 0; inval_cnt = 0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      pix_ready = (i % 2 == 0);
      cycle();
    end
    pix_ready = 1;
    chk("bp_transfers", tx_cnt, NPIX);
    chk("bp_frame_starts", fs_cnt, 1);
    chk("bp_no_bubble", inval_cnt, 0);

    // 4: drop scan_en mid-frame
    for (g = 0; g < 2000 && !(pix_valid && pix_x == 20 && pix_y == 2); g++) cycle();
    if (!(pix_valid && pix_x == 20 && pix_y == 2)) timeout("reach_20_2");
    scan_en = 0;
    for (g = 0; g < 2000 && pix_valid; g++) cycle();
    if (pix_valid) timeout("frame_end_idle");
    chk("stop_last_x", last_x, ROWPIX - 1);
    chk("stop_last_y", last_y, RW - 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_valid", pix_valid, 0);
    chk("idle_busy", busy, 0);

    // 5: clear request mid-frame, then rescan, then clear priority in IDLE
    scan_en = 1;
    for (g = 0; g < 2000 && !(pix_valid && pix_y == 1); g++) cycle();
    clear_req = 1; cycle(); clear_req = 0;
    for (g = 0; g < 2000 && !busy; g++) cycle();
    if (!busy) timeout("pending_clear");
    chk("clr_last_x", last_x, ROWPIX - 1);
    chk("clr_last_y", last_y, RW - 1);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      busy_cnt++;
      cycle();
    end
    chk("busy_cycles2", busy_cnt, NW);
    for (int i = 0; i < NPIX; i++) pixmap[i] = 1;
    tx_cnt = 0;
    for (g = 0; g < 2000 && tx_cnt < NPIX; g++) cycle();
    ones = 0;
    for (int i = 0; i < NPIX; i++) ones += pixmap[i];
    chk("rescan_zero", ones, 0);
    scan_en = 0;
    for (g = 0; g < 2000 && pix_valid; g++) cycle();
    clear_req = 1; scan_en = 1; cycle();
    clear_req = 0; scan_en = 0;
    chk("prio_busy", busy, 1);
    chk("prio_valid", pix_valid, 0);
    for (g = 0; g < 100 && busy; g++) cycle();

    // 6: writes to the held word versus a later word
    load = 1; address = 4'd2; din = 16'h1234; cycle();
    load = 0; scan_en = 1;
    for (g = 0; g < 2000 && !(pix_valid && pix_y == 0 && pix_x == 33); g++) cycle();
    if (!(pix_valid && pix_x == 33)) timeout("reach_x33");
    load = 1; address = 4'd2; din = 16'hFFFF; cycle();
    address = 4'd3; cycle();
    load = 0;
    for (g = 0; g < 2000 && !(pix_valid && pix_y == 1); g++) cycle();
    for (int i = 0; i < DW; i++) begin
      w2[i] = pixmap[32 + i];
      w3[i] = pixmap[48 + i];
    end
    chk("held_word_old", w2, 16'h1234);
    chk("later_word_new", w3, 16'hFFFF);
    reset = 1; cycle(); reset = 0;
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", busy, 1);

    // 7: randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 1499) == 0);
      load      = ($urandom_range(0, 3) == 0);
      address   = AW'($urandom_range(0, NW - 1));
      din       = DW'($urandom);
      clear_req = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
      pix_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
